// File: rtl/mulfunc.sv
// Iterative unsigned multiply-accumulate, {hi,lo} = a*b + c, one shift-add step per clock.
// Optional MULFUNC_EARLY_EN: finish as soon as no multiplier bits remain.
module mulfunc #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] c,
    input  logic            vld,
    output logic            rdy,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] hi,
    output logic            ack
);

    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LastCnt = CW'(XLEN - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mc_q, mc_d;
    logic [XLEN-1:0]     mp_q, mp_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                last;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (vld) begin
                    acc_d   = {{XLEN{1'b0}}, c};
                    mc_d    = {{XLEN{1'b0}}, a};
                    mp_d    = b;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (mp_q[0]) begin
                    acc_d = acc_q + mc_q;
                end
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + CW'(1);
`ifdef MULFUNC_EARLY_EN
                // Remaining steps would only shift zeros; the sum is already final.
                last  = (cnt_q == LastCnt) || (mp_d == '0);
`else
                last  = (cnt_q == LastCnt);
`endif
                if (last) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign rdy = (state_q == StIdle);
    assign ack = ack_q;
    assign lo  = acc_q[XLEN-1:0];
    assign hi  = acc_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mulfunc.sv
// Self-checking bench for mulfunc (XLEN=32): directed vector table, multi-cycle sequences,
// random ops and divider round-trips. Honours MULFUNC_EARLY_EN for expected latency.
module tb_mulfunc;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            vld;
    logic [XLEN-1:0] a, b, c;
    logic [XLEN-1:0] lo, hi;
    logic            rdy, ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mulfunc #(.XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .vld(vld),
        .rdy(rdy),
        .lo (lo),
        .hi (hi),
        .ack(ack)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [31:0] bv);
`ifdef MULFUNC_EARLY_EN
        int n = 1;
        for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    // Returns cycles from accept edge to the ack cycle; lat=0 means no ack within the bound.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tc,
                          output logic [63:0] res, output int lat);
        int guard = 0;
        while (!rdy && guard < 100) begin
            tick();
            guard++;
        end
        a = ta; b = tb_v; c = tc; vld = 1'b1;
        tick();
        vld = 1'b0;
        a = $urandom; b = $urandom; c = $urandom;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ack) begin
                lat = i;
                res = {hi, lo};
                break;
            end
        end
    endtask

    task automatic count_acks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ack) n++;
        end
    endtask

    initial begin
        vec_t        vecs[12];
        logic [63:0] res;
        logic [31:0] ra, rb, rc, q, r;
        int          lat, n;

        vecs[0]  = '{32'd7,        32'd6,        32'd0,        64'd42};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000};
        vecs[2]  = '{32'h12345678, 32'h9ABCDEF0, 32'd5,        64'h0B00EA4E_242D2085};
        vecs[3]  = '{32'd0,        32'd0,        32'h1234,     64'h00000000_00001234};
        vecs[4]  = '{32'd1,        32'hFFFFFFFF, 32'd0,        64'h00000000_FFFFFFFF};
        vecs[5]  = '{32'h80000000, 32'd2,        32'd0,        64'h00000001_00000000};
        vecs[6]  = '{32'd3,        32'h80000000, 32'd0,        64'h00000001_80000000};
        vecs[7]  = '{32'hFFFFFFFF, 32'd2,        32'd1,        64'h00000001_FFFFFFFF};
        vecs[8]  = '{32'd5,        32'd5,        32'hFFFFFFFF, 64'h00000001_00000018};
        vecs[9]  = '{32'hDEAD,     32'd0,        32'd9,        64'h00000000_00000009};
        vecs[10] = '{32'd10,       32'd5,        32'd3,        64'h00000000_00000035};
        vecs[11] = '{32'd0,        32'hFFFFFFFF, 32'd77,       64'h00000000_0000004D};

        rst = 1'b1; vld = 1'b0; a = '0; b = '0; c = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_rdy", 64'(rdy), 64'd1);
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_result", {hi, lo}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
            tick();
            check($sformatf("vec%0d_ack_pulse", i), 64'(ack), 64'd0);
            repeat (2) tick();
            check($sformatf("vec%0d_hold", i), {hi, lo}, vecs[i].exp);
        end

        // Back-to-back: second request raised in the ack cycle, extra vld during BUSY ignored.
        a = 32'd7; b = 32'd6; c = 32'd0; vld = 1'b1;
        tick();
        vld = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ack) begin
                lat = i;
                break;
            end
        end
        check("b2b_first_latency", 64'(lat), 64'(exp_lat(32'd6)));
        check("b2b_first_result", {hi, lo}, 64'd42);
        check("b2b_rdy_in_ack", 64'(rdy), 64'd1);
        a = 32'h12345678; b = 32'h9ABCDEF0; c = 32'd5; vld = 1'b1;
        tick();
        check("b2b_busy_rdy", 64'(rdy), 64'd0);
        a = 32'd1; b = 32'd1; c = 32'd1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 5) vld = 1'b0;
            if (ack) begin
                lat = i;
                break;
            end
        end
        check("b2b_second_latency", 64'(lat), 64'd32);
        check("b2b_second_result", {hi, lo}, 64'h0B00EA4E_242D2085);
        count_acks(40, n);
        check("busy_vld_ignored", 64'(n), 64'd0);
        check("b2b_idle_rdy", 64'(rdy), 64'd1);

        // Reset during step 10 drops the op with no ack.
        a = 32'd3; b = 32'hFFFFFFFF; c = 32'd1; vld = 1'b1;
        tick();
        vld = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rdy", 64'(rdy), 64'd1);
        check("midrst_ack", 64'(ack), 64'd0);
        check("midrst_result", {hi, lo}, 64'd0);
        count_acks(40, n);
        check("midrst_no_ack", 64'(n), 64'd0);

        // rst and vld on the same edge: request dropped.
        a = 32'd2; b = 32'd2; c = 32'd2; rst = 1'b1; vld = 1'b1;
        tick();
        rst = 1'b0; vld = 1'b0;
        check("rst_vld_rdy", 64'(rdy), 64'd1);
        count_acks(40, n);
        check("rst_vld_no_ack", 64'(n), 64'd0);

        run_op(32'd3, 32'd5, 32'd1, res, lat);
        check("post_rst_result", res, 64'd16);
        check("post_rst_latency", 64'(lat), 64'(exp_lat(32'd5)));

        for (int i = 0; i < 250; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
            run_op(ra, rb, rc, res, lat);
            check($sformatf("rand%0d_result", i), res, 64'(ra) * 64'(rb) + 64'(rc));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(rb)));
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 65535)) : ($urandom | 32'd1);
            q = ra / rb;
            r = ra % rb;
            run_op(q, rb, r, res, lat);
            check($sformatf("div%0d_roundtrip", i), res, {32'd0, ra});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
